led_breath_sequencer: RTL and testbench
=======================================

// Module: led_breath_sequencer
// PURPOSE
//   Upstream duty-cycle sequencer for the LED PWM stage. Generates the 8-bit
//   brightness ramp: rise, hold high, fall, hold low, repeat. Each step is
//   paced by the PWM stage's end-of-period pulse, so duty changes align with
//   PWM period boundaries. The PWM stage latches duty when duty_load pulses.
// PARAMETERS
//   DUTY_W       8    duty width in bits
//   MIN_DUTY     0    floor brightness; must be < MAX_DUTY
//   MAX_DUTY     255  ceiling brightness; must be <= 2**DUTY_W-1
//   STEP_SIZE    1    duty increment/decrement per step; must be >= 1
//   STEP_DIV     1    period_done pulses per ramp step; must be >= 1
//   HOLD_PERIODS 16   period_done pulses spent in each hold state; 0 = no hold
// PORTS
//   clk          in   1       system clock, all logic on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   enable       in   1       level; 1 = run sequence, 0 = force IDLE
//   oneshot      in   1       level, sampled in HOLD_LOW exit; 1 = stop after cycle
//   period_done  in   1       1-cycle pulse from PWM stage at counter wrap
//   duty         out  DUTY_W  current brightness value
//   duty_load    out  1       1-cycle pulse on every clock edge where duty changes
//   state        out  3       0 IDLE,1 RAMP_UP,2 HOLD_HIGH,3 RAMP_DOWN,4 HOLD_LOW
//   cycle_done   out  1       1-cycle pulse when HOLD_LOW completes
// BEHAVIOUR
//   - Reset (async, rst_n=0): duty=MIN_DUTY, duty_load=0, state=IDLE,
//     cycle_done=0, step divider and hold counter = 0. All outputs registered.
//   - Only period_done advances the sequence; no other timebase inside.
//   - Step divider counts period_done 0..STEP_DIV-1; "step" = period_done while
//     divider is at STEP_DIV-1; divider then wraps to 0. Cleared on entry to
//     each state.
//   - IDLE: duty=MIN_DUTY. enable=1 -> RAMP_UP next edge (no duty change).
//   - RAMP_UP: on step, duty <= min(duty+STEP_SIZE, MAX_DUTY), computed in
//     DUTY_W+1 bits (no wrap). When new duty == MAX_DUTY -> HOLD_HIGH same edge.
//   - HOLD_HIGH: hold counter counts period_done; after HOLD_PERIODS pulses
//     -> RAMP_DOWN. HOLD_PERIODS=0: skip; RAMP_UP goes directly to RAMP_DOWN.
//   - RAMP_DOWN: on step, duty <= max(duty-STEP_SIZE, MIN_DUTY), signed-safe
//     (no underflow). When new duty == MIN_DUTY -> HOLD_LOW same edge.
//   - HOLD_LOW: after HOLD_PERIODS pulses: cycle_done=1 for one cycle; next
//     state IDLE if oneshot=1 (stays IDLE until enable falls and rises again),
//     else RAMP_UP. HOLD_PERIODS=0: exit on the edge entering HOLD_LOW.
//   - Latency: duty and duty_load update on the clk edge that samples the
//     qualifying period_done; duty_load high exactly that one cycle.
//   - enable=0 (any state): next edge state=IDLE, duty=MIN_DUTY, counters
//     cleared; duty_load pulses only if duty was != MIN_DUTY. enable=0 wins over
//     simultaneous period_done. cycle_done never asserted on abort.
//   - oneshot IDLE latch: after oneshot stop, restart needs enable low >=1 cycle.
//   - period_done wider than 1 cycle counts once per asserted cycle (caller
//     guarantees single-cycle pulses).
//   - Reset mid-ramp: immediate return to reset values, no duty_load pulse.
// TESTING
//   1 Reset: hold rst_n=0, toggle inputs -> duty=0, state=0, duty_load=0,
//     cycle_done=0; release, enable=0 -> remains IDLE.
//   2 Full ramp (defaults): enable=1, period_done every 4 clks -> duty 0..255 in
//     255 duty_load pulses, state 2 on reaching 255, back to 0 via 255 pulses,
//     then HOLD_LOW, cycle_done after 16 more period_done.
//   3 Saturation: STEP_SIZE=100 -> up sequence 100,200,255; down 155,55,0;
//     never wraps.
//   4 Divider/hold: STEP_DIV=3, HOLD_PERIODS=5 -> duty moves every 3rd
//     period_done; HOLD_HIGH lasts exactly 5 period_done; HOLD_PERIODS=0 ->
//     RAMP_UP steps straight to RAMP_DOWN.
//   5 Abort: drop enable at duty=37 together with period_done -> next edge
//     duty=0, duty_load=1, state=IDLE, no cycle_done; re-enable restarts at 0.
//   6 Oneshot + async reset: oneshot=1 -> one cycle_done, then IDLE; assert
//     rst_n mid-RAMP_DOWN off-edge -> outputs reset immediately.

Source files
------------

// File: rtl/led_breath_sequencer.sv
// ============================================================================
//  led_breath_sequencer : PWM duty ramp sequencer (rise, hold, fall, hold)
//  Revision 1.0
// ============================================================================
`default_nettype none

module led_breath_sequencer #(
    parameter int DUTY_W       = 8,
    parameter int MIN_DUTY     = 0,
    parameter int MAX_DUTY     = 255,
    parameter int STEP_SIZE    = 1,
    parameter int STEP_DIV     = 1,
    parameter int HOLD_PERIODS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              oneshot,
    input  logic              period_done,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_load,
    output logic [2:0]        state,
    output logic              cycle_done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD_HIGH = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD_LOW  = 3'd4
    } state_t;

    localparam int c_div_w  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int c_hold_w = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(STEP_DIV - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'((HOLD_PERIODS > 0) ? HOLD_PERIODS - 1 : 0);
    localparam logic [DUTY_W-1:0]   c_min_duty  = DUTY_W'(MIN_DUTY);
    localparam logic [DUTY_W-1:0]   c_max_duty  = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0]   c_step      = DUTY_W'(STEP_SIZE);
    localparam logic [DUTY_W:0]     c_max_ext   = (DUTY_W+1)'(MAX_DUTY);
    localparam logic [DUTY_W:0]     c_step_ext  = (DUTY_W+1)'(STEP_SIZE);
    localparam logic [DUTY_W:0]     c_down_min  = (DUTY_W+1)'(MIN_DUTY + STEP_SIZE);

    state_t                state_q, state_d;
    logic [DUTY_W-1:0]     duty_q, duty_d;
    logic                  duty_load_q, duty_load_d;
    logic                  cycle_done_q, cycle_done_d;
    logic [c_div_w-1:0]    div_q, div_d;
    logic [c_hold_w-1:0]   hold_q, hold_d;
    logic                  lock_q, lock_d;

    logic                  w_step;
    logic                  w_end_cycle;
    logic [DUTY_W:0]       w_up_sum;
    logic [DUTY_W-1:0]     w_up_next;
    logic [DUTY_W-1:0]     w_down_next;

    // Ramp arithmetic carries one extra bit so saturation never wraps.
    assign w_step      = period_done && (div_q == c_div_last);
    assign w_up_sum    = {1'b0, duty_q} + c_step_ext;
    assign w_up_next   = (w_up_sum > c_max_ext) ? c_max_duty : w_up_sum[DUTY_W-1:0];
    assign w_down_next = ({1'b0, duty_q} >= c_down_min) ? (duty_q - c_step) : c_min_duty;

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        cycle_done_d = 1'b0;
        div_d        = div_q;
        hold_d       = hold_q;
        lock_d       = lock_q;
        w_end_cycle  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!lock_q) begin
                    state_d = ST_RAMP_UP;
                    div_d   = '0;
                    hold_d  = '0;
                end
            end
            ST_RAMP_UP: begin
                if (period_done) begin
                    div_d = div_q + 1'b1;
                end
                if (w_step) begin
                    div_d  = '0;
                    duty_d = w_up_next;
                    if (w_up_next == c_max_duty) begin
                        state_d = (HOLD_PERIODS == 0) ? ST_RAMP_DOWN : ST_HOLD_HIGH;
                        hold_d  = '0;
                    end
                end
            end
            ST_HOLD_HIGH: begin
                if (period_done) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == c_hold_last) begin
                        state_d = ST_RAMP_DOWN;
                        hold_d  = '0;
                        div_d   = '0;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (period_done) begin
                    div_d = div_q + 1'b1;
                end
                if (w_step) begin
                    div_d  = '0;
                    duty_d = w_down_next;
                    if (w_down_next == c_min_duty) begin
                        hold_d = '0;
                        if (HOLD_PERIODS == 0) begin
                            w_end_cycle = 1'b1;
                        end else begin
                            state_d = ST_HOLD_LOW;
                        end
                    end
                end
            end
            ST_HOLD_LOW: begin
                if (period_done) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == c_hold_last) begin
                        w_end_cycle = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                duty_d  = c_min_duty;
            end
        endcase

        // A oneshot stop parks in IDLE until enable is dropped and reasserted.
        if (w_end_cycle) begin
            cycle_done_d = 1'b1;
            div_d        = '0;
            hold_d       = '0;
            if (oneshot) begin
                state_d = ST_IDLE;
                lock_d  = 1'b1;
            end else begin
                state_d = ST_RAMP_UP;
            end
        end

        if (!enable) begin
            state_d      = ST_IDLE;
            duty_d       = c_min_duty;
            cycle_done_d = 1'b0;
            div_d        = '0;
            hold_d       = '0;
            lock_d       = 1'b0;
        end

        duty_load_d = (duty_d != duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            duty_q       <= c_min_duty;
            duty_load_q  <= 1'b0;
            cycle_done_q <= 1'b0;
            div_q        <= '0;
            hold_q       <= '0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            duty_load_q  <= duty_load_d;
            cycle_done_q <= cycle_done_d;
            div_q        <= div_d;
            hold_q       <= hold_d;
            lock_q       <= lock_d;
        end
    end

    assign duty       = duty_q;
    assign duty_load  = duty_load_q;
    assign state      = state_q;
    assign cycle_done = cycle_done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_breath_sequencer.sv
// ============================================================================
//  tb_led_breath_sequencer : directed bench for led_breath_sequencer
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_led_breath_sequencer;

    logic clk;
    logic rst_n;
    logic pd;

    logic       en_def, os_def, dl_def, cd_def;
    logic [7:0] duty_def;
    logic [2:0] st_def;
    logic       en_sat, os_sat, dl_sat, cd_sat;
    logic [7:0] duty_sat;
    logic [2:0] st_sat;
    logic       en_div, os_div, dl_div, cd_div;
    logic [7:0] duty_div;
    logic [2:0] st_div;
    logic       en_nh, os_nh, dl_nh, cd_nh;
    logic [7:0] duty_nh;
    logic [2:0] st_nh;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;

    led_breath_sequencer u_def (
        .clk(clk), .rst_n(rst_n), .enable(en_def), .oneshot(os_def), .period_done(pd),
        .duty(duty_def), .duty_load(dl_def), .state(st_def), .cycle_done(cd_def)
    );

    led_breath_sequencer #(.STEP_SIZE(100), .HOLD_PERIODS(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(en_sat), .oneshot(os_sat), .period_done(pd),
        .duty(duty_sat), .duty_load(dl_sat), .state(st_sat), .cycle_done(cd_sat)
    );

    led_breath_sequencer #(.STEP_SIZE(85), .STEP_DIV(3), .HOLD_PERIODS(5)) u_div (
        .clk(clk), .rst_n(rst_n), .enable(en_div), .oneshot(os_div), .period_done(pd),
        .duty(duty_div), .duty_load(dl_div), .state(st_div), .cycle_done(cd_div)
    );

    led_breath_sequencer #(.STEP_SIZE(128), .HOLD_PERIODS(0)) u_nh (
        .clk(clk), .rst_n(rst_n), .enable(en_nh), .oneshot(os_nh), .period_done(pd),
        .duty(duty_nh), .duty_load(dl_nh), .state(st_nh), .cycle_done(cd_nh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dl_def === 1'b1) load_cnt = load_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One PWM period of 4 clocks; returns 1 time unit after the edge that sampled period_done.
    task automatic period();
        repeat (3) @(posedge clk);
        #1 pd = 1'b1;
        @(posedge clk);
        #1 pd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pd = 1'b0;
        en_def = 1'b0; os_def = 1'b0; en_sat = 1'b0; os_sat = 1'b0;
        en_div = 1'b0; os_div = 1'b0; en_nh = 1'b0; os_nh = 1'b0;

        // Reset holds while inputs toggle
        repeat (4) begin
            @(posedge clk);
            #1 en_def = ~en_def; pd = ~pd;
        end
        check("rst_duty", 32'(duty_def), 32'd0);
        check("rst_state", 32'(st_def), 32'd0);
        check("rst_load", 32'(dl_def), 32'd0);
        check("rst_cdone", 32'(cd_def), 32'd0);
        en_def = 1'b0; pd = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_disabled", 32'(st_def), 32'd0);

        // Full default ramp
        en_def = 1'b1;
        @(posedge clk); #1;
        check("start_state", 32'(st_def), 32'd1);
        check("start_duty", 32'(duty_def), 32'd0);
        period();
        check("first_step_duty", 32'(duty_def), 32'd1);
        check("first_step_load", 32'(dl_def), 32'd1);
        @(posedge clk); #1;
        check("load_one_cycle", 32'(dl_def), 32'd0);
        repeat (253) period();
        check("up_254_duty", 32'(duty_def), 32'd254);
        check("up_254_state", 32'(st_def), 32'd1);
        period();
        check("top_duty", 32'(duty_def), 32'd255);
        check("top_state", 32'(st_def), 32'd2);
        repeat (15) period();
        check("hold_hi_15_state", 32'(st_def), 32'd2);
        check("up_load_count", 32'(load_cnt), 32'd255);
        period();
        check("hold_hi_16_state", 32'(st_def), 32'd3);
        check("hold_hi_16_duty", 32'(duty_def), 32'd255);
        repeat (255) period();
        check("bottom_duty", 32'(duty_def), 32'd0);
        check("bottom_state", 32'(st_def), 32'd4);
        repeat (15) period();
        check("hold_lo_15_state", 32'(st_def), 32'd4);
        check("hold_lo_15_cdone", 32'(cd_def), 32'd0);
        check("total_load_count", 32'(load_cnt), 32'd510);
        period();
        check("cycle_done_pulse", 32'(cd_def), 32'd1);
        check("restart_state", 32'(st_def), 32'd1);
        @(posedge clk); #1;
        check("cycle_done_width", 32'(cd_def), 32'd0);

        // Abort with simultaneous period_done at duty 37
        repeat (37) period();
        check("pre_abort_duty", 32'(duty_def), 32'd37);
        repeat (3) @(posedge clk);
        #1 en_def = 1'b0; pd = 1'b1;
        @(posedge clk);
        #1 pd = 1'b0;
        check("abort_duty", 32'(duty_def), 32'd0);
        check("abort_load", 32'(dl_def), 32'd1);
        check("abort_state", 32'(st_def), 32'd0);
        check("abort_cdone", 32'(cd_def), 32'd0);
        en_def = 1'b1;
        @(posedge clk); #1;
        check("reenable_state", 32'(st_def), 32'd1);
        check("reenable_duty", 32'(duty_def), 32'd0);
        period();
        check("reenable_step", 32'(duty_def), 32'd1);
        en_def = 1'b0;
        @(posedge clk); #1;

        // Saturating steps of 100
        en_sat = 1'b1;
        @(posedge clk); #1;
        period(); check("sat_up1", 32'(duty_sat), 32'd100);
        period(); check("sat_up2", 32'(duty_sat), 32'd200);
        period(); check("sat_up3", 32'(duty_sat), 32'd255);
        check("sat_top_state", 32'(st_sat), 32'd2);
        period(); check("sat_hold1", 32'(st_sat), 32'd2);
        period(); check("sat_hold2", 32'(st_sat), 32'd3);
        period(); check("sat_dn1", 32'(duty_sat), 32'd155);
        period(); check("sat_dn2", 32'(duty_sat), 32'd55);
        period(); check("sat_dn3", 32'(duty_sat), 32'd0);
        check("sat_bottom_state", 32'(st_sat), 32'd4);

        // Oneshot stop and IDLE latch
        os_sat = 1'b1;
        period(); check("os_hold1_cdone", 32'(cd_sat), 32'd0);
        period();
        check("os_cdone", 32'(cd_sat), 32'd1);
        check("os_idle", 32'(st_sat), 32'd0);
        @(posedge clk); #1;
        check("os_cdone_width", 32'(cd_sat), 32'd0);
        period();
        check("os_latched", 32'(st_sat), 32'd0);
        check("os_latched_duty", 32'(duty_sat), 32'd0);
        en_sat = 1'b0;
        @(posedge clk);
        #1 en_sat = 1'b1; os_sat = 1'b0;
        @(posedge clk); #1;
        check("os_restart", 32'(st_sat), 32'd1);

        // Asynchronous reset in the middle of RAMP_DOWN
        repeat (6) period();
        check("mid_down_duty", 32'(duty_sat), 32'd155);
        check("mid_down_state", 32'(st_sat), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_duty", 32'(duty_sat), 32'd0);
        check("async_rst_state", 32'(st_sat), 32'd0);
        check("async_rst_load", 32'(dl_sat), 32'd0);
        en_sat = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Divider of 3, hold of 5
        en_div = 1'b1;
        @(posedge clk); #1;
        period(); period();
        check("div_no_step", 32'(duty_div), 32'd0);
        period();
        check("div_step", 32'(duty_div), 32'd85);
        check("div_step_load", 32'(dl_div), 32'd1);
        repeat (6) period();
        check("div_top", 32'(duty_div), 32'd255);
        check("div_top_state", 32'(st_div), 32'd2);
        repeat (4) period();
        check("div_hold4", 32'(st_div), 32'd2);
        period();
        check("div_hold5", 32'(st_div), 32'd3);
        period(); period();
        check("div_dn_wait", 32'(duty_div), 32'd255);
        period();
        check("div_dn_step", 32'(duty_div), 32'd170);
        en_div = 1'b0;
        @(posedge clk); #1;

        // No hold phases
        en_nh = 1'b1;
        @(posedge clk); #1;
        period(); check("nh_up1", 32'(duty_nh), 32'd128);
        period();
        check("nh_top", 32'(duty_nh), 32'd255);
        check("nh_skip_hold", 32'(st_nh), 32'd3);
        period(); check("nh_dn1", 32'(duty_nh), 32'd127);
        period();
        check("nh_bottom", 32'(duty_nh), 32'd0);
        check("nh_cdone", 32'(cd_nh), 32'd1);
        check("nh_restart", 32'(st_nh), 32'd1);
        en_nh = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
